// File: rtl/fc_pkg.sv
// Shared types, widths and result-shaping helpers for the F6 fully connected stage.
// Word and accumulator widths are fixed here; the stage's DATA_WIDTH must match WORD_WIDTH.
package fc_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int ACC_WIDTH  = 2 * WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE,
    DONE
  } state_t;

  // Clamp a wide signed value into the signed word range.
  function automatic logic [WORD_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] value);
    logic signed [ACC_WIDTH-1:0] max_v;
    logic signed [ACC_WIDTH-1:0] min_v;
    max_v = {{(ACC_WIDTH-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
    min_v = {{(ACC_WIDTH-WORD_WIDTH+1){1'b1}}, {(WORD_WIDTH-1){1'b0}}};
    if (value > max_v) begin
      return max_v[WORD_WIDTH-1:0];
    end else if (value < min_v) begin
      return min_v[WORD_WIDTH-1:0];
    end else begin
      return value[WORD_WIDTH-1:0];
    end
  endfunction

  function automatic logic [WORD_WIDTH-1:0] relu(input logic [WORD_WIDTH-1:0] value,
                                                 input logic                  enable);
    return (enable && value[WORD_WIDTH-1]) ? '0 : value;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Fixed-point multiply-accumulate datapath for one neuron: scaled product, wrapping
// accumulator, and a finalize path that adds the bias, saturates and applies ReLU.
module fc_mac
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int FRAC_BITS  = 16,
  parameter bit RELU       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accumulate,
  input  logic                  finalize,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] weight,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [DATA_WIDTH-1:0] result
);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0] total;

  always_comb begin
    product = (ACC_WIDTH'($signed(data)) * ACC_WIDTH'($signed(weight))) >>> FRAC_BITS;
    // The last product never enters acc; it is folded in together with the bias.
    total   = acc + product + ACC_WIDTH'($signed(bias));
    result  = finalize ? relu(saturate(total), RELU) : '0;
  end

  // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accumulate) begin
      acc <= acc + product;
    end
  end

endmodule

// File: rtl/fc_f6_unit.sv
// F6 fully connected stage: streams NIN inputs per neuron from the upstream buffer,
// accumulates against internal weight/bias RAMs and writes NOUT results downstream.
module fc_f6_unit
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH        = WORD_WIDTH,
  parameter int ADDRESS_BITS      = 15,
  parameter int FRAC_BITS         = 16,
  parameter int NUMBER_OF_INPUTS  = 120,
  parameter int NUMBER_OF_OUTPUTS = 84,
  parameter bit RELU              = 1'b1,
  parameter int ADDRESS_SIZE_IN   = $clog2(NUMBER_OF_INPUTS),
  parameter int ADDRESS_SIZE_OUT  = $clog2(NUMBER_OF_OUTPUTS),
  parameter int ADDRESS_SIZE_WM   = $clog2(NUMBER_OF_INPUTS * NUMBER_OF_OUTPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       riscv_data,
  input  logic [ADDRESS_BITS-1:0]     riscv_address,
  input  logic                        wm_enable_write,
  input  logic                        bm_enable_write,
  input  logic                        start_from_previous,
  input  logic [DATA_WIDTH-1:0]       data_in_from_previous,
  output logic                        ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IN-1:0]  ifm_address_read_current,
  output logic                        end_to_previous,
  output logic                        ready,
  input  logic                        end_from_next,
  output logic [DATA_WIDTH-1:0]       data_out_for_next,
  output logic                        ifm_enable_write_next,
  output logic [ADDRESS_SIZE_OUT-1:0] ifm_address_write_next,
  output logic                        start_to_next
);

  localparam int NIN      = NUMBER_OF_INPUTS;
  localparam int NOUT     = NUMBER_OF_OUTPUTS;
  localparam int WM_DEPTH = NIN * NOUT;

  state_t state;
  state_t state_next;

  logic [ADDRESS_SIZE_IN-1:0]  in_idx;
  logic [ADDRESS_SIZE_OUT-1:0] out_idx;
  logic [ADDRESS_SIZE_WM-1:0]  w_addr;
  logic                        start_pending;
  logic                        next_free;
  logic                        accept;
  logic                        last_in;
  logic                        last_out;

  logic [DATA_WIDTH-1:0] weight_mem [WM_DEPTH];
  logic [DATA_WIDTH-1:0] bias_mem   [NOUT];
  logic [DATA_WIDTH-1:0] weight_q;
  logic [DATA_WIDTH-1:0] bias_q;

  logic [ADDRESS_SIZE_WM-1:0]  wm_addr;
  logic [ADDRESS_SIZE_OUT-1:0] bm_addr;
  logic                        wm_write;
  logic                        bm_write;
  logic                        address_unused;

  assign wm_addr        = riscv_address[ADDRESS_SIZE_WM-1:0];
  assign bm_addr        = riscv_address[ADDRESS_SIZE_OUT-1:0];
  assign address_unused = ^riscv_address[ADDRESS_BITS-1:ADDRESS_SIZE_WM];
  // Out-of-range load addresses are dropped rather than aliasing onto real words.
  assign wm_write = wm_enable_write && ({1'b0, wm_addr} < (ADDRESS_SIZE_WM+1)'(WM_DEPTH));
  assign bm_write = bm_enable_write && ({1'b0, bm_addr} < (ADDRESS_SIZE_OUT+1)'(NOUT));

  assign last_in  = (in_idx == ADDRESS_SIZE_IN'(NIN - 1));
  assign last_out = (out_idx == ADDRESS_SIZE_OUT'(NOUT - 1));

  // NOTE: memories are deliberately not reset; only control state is, and reads are gated.
  always_ff @(posedge clk) begin
    if (wm_write) begin
      weight_mem[wm_addr] <= riscv_data;
    end
    if (bm_write) begin
      bias_mem[bm_addr] <= riscv_data;
    end
    if (state == MAC) begin
      weight_q <= weight_mem[w_addr];
    end
    if (state == MAC && last_in) begin
      bias_q <= bias_mem[out_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: defaults are assigned first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if ((start_pending || start_from_previous) && next_free) begin
          accept     = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        if (last_in) begin
          state_next = WRITE;
        end
      end
      WRITE:   state_next = last_out ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_idx  <= '0;
      out_idx <= '0;
      w_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_idx  <= '0;
            out_idx <= '0;
            w_addr  <= '0;
          end
        end
        MAC: begin
          w_addr <= w_addr + 1'b1;
          if (!last_in) begin
            in_idx <= in_idx + 1'b1;
          end
        end
        WRITE: begin
          in_idx <= '0;
          if (!last_out) begin
            out_idx <= out_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A release and a new hand-off in the same cycle leave the downstream buffer busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_pending <= 1'b0;
      next_free     <= 1'b1;
    end else begin
      start_pending <= accept ? 1'b0 : (start_pending || start_from_previous);
      if (state == DONE) begin
        next_free <= 1'b0;
      end else if (end_from_next) begin
        next_free <= 1'b1;
      end
    end
  end

  fc_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .RELU       (RELU)
  ) u_mac (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept || (state == WRITE)),
    .accumulate ((state == MAC) && (in_idx != '0)),
    .finalize   (state == WRITE),
    .data       (data_in_from_previous),
    .weight     (weight_q),
    .bias       (bias_q),
    .result     (data_out_for_next)
  );

  assign ifm_enable_read_current  = (state == MAC);
  assign ifm_address_read_current = (state == MAC) ? in_idx : '0;
  assign ifm_enable_write_next    = (state == WRITE);
  assign ifm_address_write_next   = (state == WRITE) ? out_idx : '0;
  assign start_to_next            = (state == DONE);
  assign end_to_previous          = (state == DONE);
  assign ready                    = (state == IDLE) && !start_pending;

endmodule
